// File: rtl/router_oport_pkg.sv
`default_nettype none
// ============================================================================
// Module      : router_oport_pkg
// Description : Shared types and constants for the router output-port
//               credit controller: default flit width and credit depth,
//               FIFO occupancy/pointer types and the statistics counter
//               width.
// Revision    : 1.0 - initial release
// ============================================================================
package router_oport_pkg;

    localparam int DEFAULT_DATA_W  = 32;
    localparam int DEFAULT_CREDITS = 4;
    localparam int STATS_W         = 16;

    typedef logic [DEFAULT_DATA_W-1:0] flit_t;
    typedef logic [1:0]                occ_t;
    typedef logic                      ptr_t;

    // Occupancy values of the two-entry skid FIFO
    localparam occ_t c_OCC_EMPTY = 2'd0;
    localparam occ_t c_OCC_FULL  = 2'd2;

endpackage : router_oport_pkg
`default_nettype wire

// File: rtl/router_skid_fifo2.sv
`default_nettype none
// ============================================================================
// Module      : router_skid_fifo2
// Description : Two-entry skid FIFO with registered occupancy.
//               A push is refused whenever the FIFO is full, even if a pop
//               happens in the same cycle, so the full flag depends only on
//               registered state. A pop on an empty FIFO is ignored.
// Ports       : clk, rst      - clock, synchronous active-high reset
//               i_push/i_data - write request and payload
//               i_pop         - remove the head entry
//               o_occ         - occupancy (0..2)
//               o_head        - oldest entry (valid when o_occ != 0)
// Revision    : 1.0 - initial release
// ============================================================================
module router_skid_fifo2
    import router_oport_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_pop,
    output occ_t              o_occ,
    output logic [DATA_W-1:0] o_head
);

    logic [DATA_W-1:0] r_mem [0:1];
    ptr_t              r_wr_ptr;
    ptr_t              r_rd_ptr;
    occ_t              r_occ;

    logic w_push;
    logic w_pop;

    assign w_push = i_push && (r_occ != c_OCC_FULL);
    assign w_pop  = i_pop  && (r_occ != c_OCC_EMPTY);

    // Storage carries no reset: contents are only meaningful under r_occ.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_occ    <= c_OCC_EMPTY;
        end else begin
            if (w_push) begin
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            // Simultaneous push and pop leaves occupancy unchanged
            unique case ({w_push, w_pop})
                2'b10:   r_occ <= r_occ + 2'd1;
                2'b01:   r_occ <= r_occ - 2'd1;
                default: r_occ <= r_occ;
            endcase
        end
    end

    assign o_occ  = r_occ;
    assign o_head = r_mem[r_rd_ptr];

endmodule : router_skid_fifo2
`default_nettype wire

// File: rtl/router_oport_credit_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : router_oport_credit_ctrl
// Description : Output-port flow-control stage. Flits granted by the
//               crossbar are buffered in a two-entry skid FIFO and issued
//               downstream as registered single-cycle valid/data pulses,
//               gated by a credit counter mirroring downstream buffer space.
// Ports       : clk, reset     - clock, synchronous active-high reset
//               in_valid/in_data/in_ready - crossbar-side handshake
//               credit_in      - one-cycle pulse, downstream freed a slot
//               ovalid/odata   - registered flit pulse to downstream
//               credits_avail  - current credit count
//               credit_err     - sticky credit-overflow flag
//               flits_sent, stall_cycles - statistics (optional)
// Options     : `define ROUTER_OPORT_STATS_EN adds the flits_sent and
//               stall_cycles counters and ports.
// Revision    : 1.0 - initial release
// ============================================================================
module router_oport_credit_ctrl
    import router_oport_pkg::*;
#(
    parameter int DATA_W  = DEFAULT_DATA_W,
    parameter int CREDITS = DEFAULT_CREDITS,
    parameter int CNT_W   = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    input  logic [DATA_W-1:0]  in_data,
    output logic               in_ready,
    input  logic               credit_in,
    output logic               ovalid,
    output logic [DATA_W-1:0]  odata,
    output logic [CNT_W-1:0]   credits_avail,
    output logic               credit_err
`ifdef ROUTER_OPORT_STATS_EN
    ,
    output logic [STATS_W-1:0] flits_sent,
    output logic [STATS_W-1:0] stall_cycles
`endif
);

    localparam logic [CNT_W-1:0] c_CREDITS_MAX = CNT_W'(CREDITS);
    localparam logic [CNT_W-1:0] c_CNT_ONE     = CNT_W'(1);

    occ_t              w_occ;
    logic [DATA_W-1:0] w_head;
    logic              w_push;
    logic              w_send;

    logic              r_ovalid;
    logic [DATA_W-1:0] r_odata;
    logic [CNT_W-1:0]  r_credits;
    logic              r_credit_err;
    logic [CNT_W-1:0]  w_credits_nxt;
    logic              w_credit_err_nxt;

    // Ready depends only on registered occupancy and reset, never on pop
    assign in_ready = (w_occ != c_OCC_FULL) && !reset;
    assign w_push   = in_valid && in_ready;

    // Send whenever a flit is buffered and downstream has space; since
    // send requires a credit the counter can never underflow.
    assign w_send = (w_occ != c_OCC_EMPTY) && (r_credits != '0);

    router_skid_fifo2 #(
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk    (clk),
        .rst    (reset),
        .i_push (w_push),
        .i_data (in_data),
        .i_pop  (w_send),
        .o_occ  (w_occ),
        .o_head (w_head)
    );

    always_comb begin
        w_credits_nxt    = r_credits;
        w_credit_err_nxt = r_credit_err;
        unique case ({w_send, credit_in})
            2'b10: w_credits_nxt = r_credits - c_CNT_ONE;
            2'b01: begin
                // A returned credit with nothing outstanding is a protocol
                // error downstream: saturate and latch the flag.
                if (r_credits == c_CREDITS_MAX) begin
                    w_credit_err_nxt = 1'b1;
                end else begin
                    w_credits_nxt = r_credits + c_CNT_ONE;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ovalid     <= 1'b0;
            r_odata      <= '0;
            r_credits    <= c_CREDITS_MAX;
            r_credit_err <= 1'b0;
        end else begin
            r_ovalid     <= w_send;
            r_credits    <= w_credits_nxt;
            r_credit_err <= w_credit_err_nxt;
            if (w_send) begin
                r_odata <= w_head;
            end
        end
    end

    assign ovalid        = r_ovalid;
    assign odata         = r_odata;
    assign credits_avail = r_credits;
    assign credit_err    = r_credit_err;

`ifdef ROUTER_OPORT_STATS_EN
    logic               w_stall;
    logic [STATS_W-1:0] r_flits_sent;
    logic [STATS_W-1:0] r_stall_cycles;

    assign w_stall = (w_occ != c_OCC_EMPTY) && (r_credits == '0);

    // Both counters wrap naturally modulo 2^STATS_W
    always_ff @(posedge clk) begin
        if (reset) begin
            r_flits_sent   <= '0;
            r_stall_cycles <= '0;
        end else begin
            if (w_send) begin
                r_flits_sent <= r_flits_sent + STATS_W'(1);
            end
            if (w_stall) begin
                r_stall_cycles <= r_stall_cycles + STATS_W'(1);
            end
        end
    end

    assign flits_sent   = r_flits_sent;
    assign stall_cycles = r_stall_cycles;
`endif

endmodule : router_oport_credit_ctrl
`default_nettype wire
